branch_target_arbiter: RTL
==========================

// Module: branch_target_arbiter
// PURPOSE
//  Shares one branch/jump target calculator (offset<<2 + PC+4, or J-type pseudo-direct) between
//  the two issue pipelines. Round-robin arbitration, valid/ready handshakes, 2-stage registered
//  pipeline (capture, result) with per-pipe flush. Sits between each pipe's ID stage and its PC-select mux.
// PARAMETERS
//  TAG_W   4   width of requester tag (ROB/instr id) carried through unchanged
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-high reset
//  reqN_valid     in   1      (N=0,1) request from pipe N
//  reqN_ready     out  1      request accepted this cycle when valid&ready
//  reqN_pc4       in   32     PC+4 of the branch/jump
//  reqN_imm       in   32     sign-extended branch offset (branch) / instr[25:0] in bits 25:0 (jump)
//  reqN_jump      in   1      1 = J-type pseudo-direct, 0 = PC-relative branch
//  reqN_tag       in   TAG_W  returned on respN_tag
//  flushN         in   1      kill all in-flight and same-cycle requests of pipe N
//  respN_valid    out  1      result for pipe N valid (registered)
//  respN_ready    in   1      pipe N consumes result
//  respN_target   out  32     computed target
//  respN_tag      out  TAG_W  tag of the request
//  busy           out  1      any stage occupied
// BEHAVIOUR
//  Reset: all valid bits, reqN_ready, respN_valid, busy = 0; targets/tags = 0; last_grant = 1 (pipe 0 first).
//  Arithmetic (mod 2^32, no overflow flag): branch: target = pc4 + (imm << 2);
//   jump: target = {pc4[31:28], imm[25:0], 2'b00}. Computed between S1 and S2.
//  Pipeline: S1 {valid,owner,pc4,imm,jump,tag}; S2 {valid,owner,target,tag}.
//   s2_free = ~s2_valid | resp<owner>_ready;  s1_free = ~s1_valid | s2_free.
//   S2 loads S1 when s1_valid & s2_free; S1 loads granted request when s1_free.
//   Latency: accept in cycle T -> respN_valid in cycle T+2. Throughput 1/cycle when unstalled.
//  Arbitration (combinational grant, state in last_grant):
//   one valid -> grant it; both valid -> grant ~last_grant; last_grant <= granted id only on accept.
//   reqN_ready = granted(N) & s1_free & ~flushN. Never both ready in one cycle.
//  Handshake: respN_valid = s2_valid & s2_owner==N; holds target/tag stable until respN_ready.
//   Stall of pipe N's result blocks the shared pipe (head-of-line), so reqX_ready drops for both.
//  Flush: flushN in cycle T clears S1 and/or S2 if owned by N at the T edge; refills into the freed
//   slot proceed in that same cycle. Grant is recomputed excluding N. Flushed S2 + respN_ready
//   same cycle: entry dropped; the consumer ignores results in its own flush cycle.
//   flush0 & flush1 together: both stages empty next cycle, no accept.
//  Reset mid-operation: all in-flight entries discarded immediately (async); no response later.
//  busy = s1_valid | s2_valid.
// STRUCTURE
//  Shared package branch_pkg: PC_W=32, JUMP_IDX_W=26, OWNER_P0/OWNER_P1 constants.
//  Sub-module target_calc (combinational: pc4, imm, jump -> target); reused by single-pipe builds.
//  Top holds arbiter, S1/S2 registers, stall/flush logic.
// TESTING
//  1 branch: req0 pc4=0x00000100 imm=0x00000003 jump=0 tag=5 -> resp0 T+2 target=0x0000010C tag=5.
//  2 neg/jump: req1 imm=0xFFFFFFFF pc4=0x00000100 -> 0x000000FC; jump pc4=0xA0000004
//    imm=0x00123456 -> 0xA048D158; pc4=0xFFFFFFFC imm=0x1 -> wraps to 0x00000000.
//  3 round-robin: both valid 6 cycles after reset, resp ready=1 -> accepts 0,1,0,1,0,1; results T+2.
//  4 backpressure: resp0_ready=0 with S2 owned by 0 -> resp0 stable, req ready=0 both;
//    release -> drains in order, no loss/duplication.
//  5 flush: S1=pipe1, S2=pipe0, flush1 pulse -> pipe1 result never appears, pipe0 delivered;
//    flush0 while req0_valid -> req0_ready=0 that cycle.
//  6 reset asserted with both stages full -> all outputs 0 asynchronously; after release pipe 0 first.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared widths and owner encodings for the branch target arbiter
package branch_pkg;
  localparam int PC_W = 32;
  localparam int JUMP_IDX_W = 26;
  typedef logic owner_t;
  localparam owner_t OWNER_P0 = 1'b0;
  localparam owner_t OWNER_P1 = 1'b1;
endpackage

// File: rtl/branch_target_arbiter_if.sv
// branch_target_arbiter_if: request/response bundle between both issue pipes and the arbiter
interface branch_target_arbiter_if #(parameter int TAG_W = 4);
  import branch_pkg::*;
  logic req0_valid, req0_ready, req0_jump, flush0, resp0_valid, resp0_ready;
  logic req1_valid, req1_ready, req1_jump, flush1, resp1_valid, resp1_ready;
  logic [PC_W-1:0] req0_pc4, req0_imm, resp0_target, req1_pc4, req1_imm, resp1_target;
  logic [TAG_W-1:0] req0_tag, resp0_tag, req1_tag, resp1_tag;
  logic busy;
  modport master (
    output req0_valid, req0_pc4, req0_imm, req0_jump, req0_tag, flush0, resp0_ready,
    output req1_valid, req1_pc4, req1_imm, req1_jump, req1_tag, flush1, resp1_ready,
    input req0_ready, resp0_valid, resp0_target, resp0_tag,
    input req1_ready, resp1_valid, resp1_target, resp1_tag, busy
  );
  modport slave (
    input req0_valid, req0_pc4, req0_imm, req0_jump, req0_tag, flush0, resp0_ready,
    input req1_valid, req1_pc4, req1_imm, req1_jump, req1_tag, flush1, resp1_ready,
    output req0_ready, resp0_valid, resp0_target, resp0_tag,
    output req1_ready, resp1_valid, resp1_target, resp1_tag, busy
  );
endinterface

// File: rtl/target_calc.sv
// target_calc: PC-relative branch or pseudo-direct jump target
module target_calc import branch_pkg::*; (
  input  logic [PC_W-1:0] pc4_i,
  input  logic [PC_W-1:0] imm_i,
  input  logic            jump_i,
  output logic [PC_W-1:0] target_o
);
  always_comb target_o = jump_i ? {pc4_i[PC_W-1:JUMP_IDX_W+2], imm_i[JUMP_IDX_W-1:0], 2'b00}
                                : pc4_i + {imm_i[PC_W-3:0], 2'b00};
endmodule

// File: rtl/branch_target_arbiter.sv
// branch_target_arbiter: round-robin share of one target calculator between two pipes,
// two registered stages (capture, result) with per-pipe flush and head-of-line stall.
module branch_target_arbiter import branch_pkg::*; #(parameter int TAG_W = 4) (
  input logic clk,
  input logic reset,
  branch_target_arbiter_if.slave bus
);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s1_jump_q, s1_jump_d;
  owner_t s1_owner_q, s1_owner_d, s2_owner_q, s2_owner_d, last_grant_q, last_grant_d;
  logic [PC_W-1:0] s1_pc4_q, s1_pc4_d, s1_imm_q, s1_imm_d, s2_target_q, s2_target_d, s1_target;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [1:0] flush, rready, elig;
  logic s1_live, s2_live, s2_free, s1_free, gnt1, accept;
  target_calc u_calc (.pc4_i(s1_pc4_q), .imm_i(s1_imm_q), .jump_i(s1_jump_q), .target_o(s1_target));
  always_comb begin
    flush = {bus.flush1, bus.flush0};
    rready = {bus.resp1_ready, bus.resp0_ready};
    elig = {bus.req1_valid & ~bus.flush1, bus.req0_valid & ~bus.flush0};
    // a flushed entry frees its slot in the same cycle so the pipe can refill
    s1_live = s1_valid_q & ~flush[s1_owner_q];
    s2_live = s2_valid_q & ~flush[s2_owner_q];
    s2_free = ~s2_live | rready[s2_owner_q];
    s1_free = ~s1_live | s2_free;
    gnt1 = elig[1] & (~elig[0] | last_grant_q == OWNER_P0);
    accept = |elig & s1_free & ~reset;
    s2_valid_d = s2_free ? s1_live : s2_valid_q;
    s2_owner_d = s2_free ? s1_owner_q : s2_owner_q;
    s2_target_d = s2_free & s1_live ? s1_target : s2_target_q;
    s2_tag_d = s2_free & s1_live ? s1_tag_q : s2_tag_q;
    s1_valid_d = s1_free ? accept : s1_valid_q;
    s1_owner_d = accept ? owner_t'(gnt1) : s1_owner_q;
    s1_pc4_d = accept ? (gnt1 ? bus.req1_pc4 : bus.req0_pc4) : s1_pc4_q;
    s1_imm_d = accept ? (gnt1 ? bus.req1_imm : bus.req0_imm) : s1_imm_q;
    s1_jump_d = accept ? (gnt1 ? bus.req1_jump : bus.req0_jump) : s1_jump_q;
    s1_tag_d = accept ? (gnt1 ? bus.req1_tag : bus.req0_tag) : s1_tag_q;
    last_grant_d = accept ? owner_t'(gnt1) : last_grant_q;
    bus.req0_ready = elig[0] & ~gnt1 & s1_free & ~reset;
    bus.req1_ready = gnt1 & s1_free & ~reset;
    bus.resp0_valid = s2_valid_q & s2_owner_q == OWNER_P0;
    bus.resp1_valid = s2_valid_q & s2_owner_q == OWNER_P1;
    bus.resp0_target = s2_target_q;
    bus.resp1_target = s2_target_q;
    bus.resp0_tag = s2_tag_q;
    bus.resp1_tag = s2_tag_q;
    bus.busy = s1_valid_q | s2_valid_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_owner_q <= OWNER_P0;
      s1_pc4_q <= '0;
      s1_imm_q <= '0;
      s1_jump_q <= 1'b0;
      s1_tag_q <= '0;
      s2_valid_q <= 1'b0;
      s2_owner_q <= OWNER_P0;
      s2_target_q <= '0;
      s2_tag_q <= '0;
      last_grant_q <= OWNER_P1;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_owner_q <= s1_owner_d;
      s1_pc4_q <= s1_pc4_d;
      s1_imm_q <= s1_imm_d;
      s1_jump_q <= s1_jump_d;
      s1_tag_q <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_owner_q <= s2_owner_d;
      s2_target_q <= s2_target_d;
      s2_tag_q <= s2_tag_d;
      last_grant_q <= last_grant_d;
    end
endmodule
